// File: rtl/pipe_stage_buf_pkg.sv
// pipe_stage_buf_pkg: shared constants, handshake event type and slot helper for the stage buffer
package pipe_stage_buf_pkg;
  localparam int PSB_DEPTH_MAX = 2;
  localparam logic FLUSH = 1'b1;
  localparam int IFID_PAYLOAD_W = 64;
  localparam int IDEX_PAYLOAD_W = 160;
  localparam int EXMEM_PAYLOAD_W = 108;
  localparam int MEMWB_PAYLOAD_W = 70;
  typedef struct packed {
    logic push;
    logic pop;
  } psb_evt_t;
  // The tail slot lies one past the head when exactly one entry is stored; the plain register only uses slot 0.
  function automatic logic psb_wr_slot(input logic hp, input logic occ_lsb, input logic skid);
    return skid ? (hp ^ occ_lsb) : 1'b0;
  endfunction
endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: saturating up-counter with synchronous clear taking priority over increment
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc && r_cnt != '1) r_cnt <= r_cnt + W'(1);
  end
  assign o_cnt = r_cnt;
endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/allowin pipeline buffer, plain register (DEPTH=1) or 2-entry skid ring (DEPTH=2)
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int DATA_W       = 64,
  parameter int DEPTH        = 1,
  parameter bit CLR_ON_FLUSH = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              up_valid,
  input  logic [DATA_W-1:0] up_data,
  output logic              allowin,
  output logic              cur_valid,
  output logic [DATA_W-1:0] cur_data,
  input  logic              cur_ready_go,
  output logic              dn_valid,
  input  logic              dn_allowin,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);
  if (DEPTH < 1 || DEPTH > PSB_DEPTH_MAX) begin : g_bad_depth
    $error("pipe_stage_buf: DEPTH must be 1 or 2");
  end
  logic [1:0]        r_occ;
  logic              r_hp;
  logic [DATA_W-1:0] r_slot [2];
  psb_evt_t          w_evt;
  logic              w_flush;
  logic              w_widx;
  logic [1:0]        w_occ_nxt;
  // In skid mode allowin comes only from occupancy, breaking the combinational path from downstream.
  always_comb begin
    w_flush = (flush == FLUSH);
    cur_valid = (r_occ != 2'd0);
    cur_data = r_slot[r_hp];
    dn_valid = cur_valid & cur_ready_go;
    allowin = (DEPTH == 1) ? (!cur_valid | (cur_ready_go & dn_allowin)) : (r_occ != 2'd2);
    w_evt.push = up_valid & allowin;
    w_evt.pop = dn_valid & dn_allowin;
    w_widx = psb_wr_slot(r_hp, r_occ[0], DEPTH == 2);
    w_occ_nxt = r_occ + {1'b0, w_evt.push} - {1'b0, w_evt.pop};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= 2'd0;
      r_hp <= 1'b0;
      r_slot[0] <= '0;
      r_slot[1] <= '0;
    end else if (w_flush) begin
      r_occ <= 2'd0;
      r_hp <= 1'b0;
      if (CLR_ON_FLUSH) begin
        r_slot[0] <= '0;
        r_slot[1] <= '0;
      end
    end else begin
      r_occ <= w_occ_nxt;
      if (DEPTH == 2 && w_evt.pop) r_hp <= ~r_hp;
      if (w_evt.push) r_slot[w_widx] <= up_data;
    end
  end
  assign occupancy = r_occ;
  pipe_sat_counter #(.W(CNT_W)) u_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (cur_valid & !w_evt.pop),
    .i_clr (w_evt.pop | w_flush | !cur_valid),
    .o_cnt (stall_cnt)
  );
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed checks of plain, skid and narrow-counter configurations of pipe_stage_buf
module tb_pipe_stage_buf;
  logic clk = 1'b0;
  logic rst_n;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;

  logic a_fl, a_uv, a_al, a_cv, a_rg, a_dv, a_dna;
  logic [7:0] a_ud, a_cd;
  logic [1:0] a_occ;
  logic [15:0] a_st;
  logic b_fl, b_uv, b_al, b_cv, b_rg, b_dv, b_dna;
  logic [7:0] b_ud, b_cd;
  logic [1:0] b_occ;
  logic [15:0] b_st;
  logic c_fl, c_uv, c_al, c_cv, c_rg, c_dv, c_dna;
  logic [7:0] c_ud, c_cd;
  logic [1:0] c_occ;
  logic [2:0] c_st;

  pipe_stage_buf #(.DATA_W(8), .DEPTH(1), .CLR_ON_FLUSH(1'b0), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_fl), .up_valid(a_uv), .up_data(a_ud), .allowin(a_al),
    .cur_valid(a_cv), .cur_data(a_cd), .cur_ready_go(a_rg), .dn_valid(a_dv), .dn_allowin(a_dna),
    .occupancy(a_occ), .stall_cnt(a_st));
  pipe_stage_buf #(.DATA_W(8), .DEPTH(2), .CLR_ON_FLUSH(1'b1), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_fl), .up_valid(b_uv), .up_data(b_ud), .allowin(b_al),
    .cur_valid(b_cv), .cur_data(b_cd), .cur_ready_go(b_rg), .dn_valid(b_dv), .dn_allowin(b_dna),
    .occupancy(b_occ), .stall_cnt(b_st));
  pipe_stage_buf #(.DATA_W(8), .DEPTH(1), .CLR_ON_FLUSH(1'b1), .CNT_W(3)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(c_fl), .up_valid(c_uv), .up_data(c_ud), .allowin(c_al),
    .cur_valid(c_cv), .cur_data(c_cd), .cur_ready_go(c_rg), .dn_valid(c_dv), .dn_allowin(c_dna),
    .occupancy(c_occ), .stall_cnt(c_st));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] q[$];
    int sent, recv;
    logic m_push, m_pop;
    rst_n = 1'b1;
    {a_fl, a_uv, a_rg, a_dna, a_ud} = '0;
    {b_fl, b_uv, b_rg, b_dna, b_ud} = '0;
    {c_fl, c_uv, c_rg, c_dna, c_ud} = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_occ", 32'(a_occ), 0);
    chk("rst_a_valid", 32'(a_cv), 0);
    chk("rst_a_dnv", 32'(a_dv), 0);
    chk("rst_b_occ", 32'(b_occ), 0);
    chk("rst_b_data", 32'(b_cd), 0);
    chk("rst_b_allowin", 32'(b_al), 1);
    chk("rst_c_stall", 32'(c_st), 0);
    tick();
    rst_n = 1'b1;
    // plain register streaming
    a_rg = 1'b1; a_dna = 1'b1; a_uv = 1'b1; a_ud = 8'hA5;
    tick();
    a_ud = 8'h5A;
    @(negedge clk);
    chk("t1_data_a5", 32'(a_cd), 'hA5);
    chk("t1_dnv", 32'(a_dv), 1);
    chk("t1_occ", 32'(a_occ), 1);
    tick();
    a_uv = 1'b0;
    @(negedge clk);
    chk("t1_data_5a", 32'(a_cd), 'h5A);
    chk("t1_dnv2", 32'(a_dv), 1);
    chk("t1_occ2", 32'(a_occ), 1);
    tick();
    @(negedge clk);
    chk("t1_empty", 32'(a_cv), 0);
    chk("t1_empty_dnv", 32'(a_dv), 0);
    chk("t1_hold", 32'(a_cd), 'h5A);
    // multi-cycle hold via ready_go
    a_uv = 1'b1; a_ud = 8'h33;
    tick();
    a_rg = 1'b0; a_ud = 8'h44;
    @(negedge clk);
    chk("t2_allowin", 32'(a_al), 0);
    chk("t2_dnv", 32'(a_dv), 0);
    chk("t2_stall0", 32'(a_st), 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      @(negedge clk);
      chk("t2_stall", 32'(a_st), 32'(i));
      chk("t2_data", 32'(a_cd), 'h33);
      chk("t2_allowin_hold", 32'(a_al), 0);
    end
    a_dna = 1'b0; a_rg = 1'b1;
    #1 chk("t2_allowin_dn0", 32'(a_al), 0);
    a_dna = 1'b1;
    #1 chk("t2_allowin_dn1", 32'(a_al), 1);
    tick();
    a_uv = 1'b0;
    @(negedge clk);
    chk("t2_new", 32'(a_cd), 'h44);
    chk("t2_stall_clr", 32'(a_st), 0);
    // flush without payload clearing drops the same-cycle push
    a_fl = 1'b1; a_uv = 1'b1; a_ud = 8'h88;
    tick();
    a_fl = 1'b0; a_uv = 1'b0;
    @(negedge clk);
    chk("a_fl_valid", 32'(a_cv), 0);
    chk("a_fl_occ", 32'(a_occ), 0);
    chk("a_fl_keep", 32'(a_cd), 'h44);
    // skid fill and in-order drain
    b_rg = 1'b1; b_dna = 1'b0; b_uv = 1'b1; b_ud = 8'h11;
    tick();
    b_ud = 8'h22;
    @(negedge clk);
    chk("t3_occ1", 32'(b_occ), 1);
    chk("t3_head11", 32'(b_cd), 'h11);
    chk("t3_allowin1", 32'(b_al), 1);
    tick();
    b_ud = 8'h33;
    @(negedge clk);
    chk("t3_occ2", 32'(b_occ), 2);
    chk("t3_allowin0", 32'(b_al), 0);
    chk("t3_head11b", 32'(b_cd), 'h11);
    b_dna = 1'b1;
    #1 chk("t3_allowin_no_comb", 32'(b_al), 0);
    chk("t3_dnv", 32'(b_dv), 1);
    tick();
    b_uv = 1'b0;
    @(negedge clk);
    chk("t3_head22", 32'(b_cd), 'h22);
    chk("t3_occ_after_pop", 32'(b_occ), 1);
    tick();
    @(negedge clk);
    chk("t3_drained", 32'(b_cv), 0);
    chk("t3_occ0", 32'(b_occ), 0);
    // flush at full occupancy with push and pop pending
    b_dna = 1'b0; b_uv = 1'b1; b_ud = 8'h5C;
    tick();
    b_ud = 8'h6D;
    tick();
    @(negedge clk);
    chk("fl_pre_occ", 32'(b_occ), 2);
    chk("fl_pre_stall", 32'(b_st), 1);
    chk("fl_pre_head", 32'(b_cd), 'h5C);
    b_fl = 1'b1; b_dna = 1'b1; b_ud = 8'h7E;
    tick();
    b_fl = 1'b0; b_uv = 1'b0;
    @(negedge clk);
    chk("fl_occ", 32'(b_occ), 0);
    chk("fl_valid", 32'(b_cv), 0);
    chk("fl_slot0", 32'(b_cd), 0);
    chk("fl_slot1", 32'(u_b.r_slot[1]), 0);
    chk("fl_stall", 32'(b_st), 0);
    // random payloads with alternating dn_allowin against a queue model
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 2000 && recv < 100; cyc++) begin
      b_uv = (sent < 100) && ($urandom_range(3) != 0);
      b_ud = 8'($urandom);
      b_dna = (cyc % 2) == 1;
      #1;
      chk("rnd_occ", 32'(b_occ), 32'(q.size()));
      chk("rnd_allowin", 32'(b_al), 32'(q.size() != 2));
      if (q.size() > 0) chk("rnd_data", 32'(b_cd), 32'(q[0]));
      b_dna = !b_dna;
      #1 chk("rnd_allowin_flip", 32'(b_al), 32'(q.size() != 2));
      b_dna = !b_dna;
      #1;
      m_push = b_uv && (q.size() != 2);
      m_pop = (q.size() != 0) && b_dna;
      if (m_pop) begin
        void'(q.pop_front());
        recv++;
      end
      if (m_push) begin
        q.push_back(b_ud);
        sent++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    b_uv = 1'b0;
    chk("rnd_recv", 32'(recv), 100);
    chk("rnd_final_occ", 32'(b_occ), 0);
    // stall counter saturation, then async reset mid-stall
    c_rg = 1'b0; c_dna = 1'b1; c_uv = 1'b1; c_ud = 8'h99;
    tick();
    c_uv = 1'b0;
    @(negedge clk);
    chk("sat_stall0", 32'(c_st), 0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      @(negedge clk);
      chk("sat_stall", 32'(c_st), 32'(i > 7 ? 7 : i));
    end
    #1 rst_n = 1'b0;
    #1;
    chk("arst_occ", 32'(c_occ), 0);
    chk("arst_stall", 32'(c_st), 0);
    chk("arst_valid", 32'(c_cv), 0);
    tick();
    rst_n = 1'b1; c_rg = 1'b1; c_uv = 1'b1; c_ud = 8'h12;
    tick();
    c_uv = 1'b0;
    @(negedge clk);
    chk("post_rst_data", 32'(c_cd), 'h12);
    chk("post_rst_dnv", 32'(c_dv), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
